ervp_real_clock_alarm_scheduler: RTL and testbench

Programmable multi-channel alarm scheduler for the free-running 64-bit microsecond real clock. It holds NUM_ALARM absolute target times, with an optional period each, and shares one magnitude comparator across all channels through a round-robin scan. It raises per-channel pending flags, one-cycle fire pulses and a combined interrupt. It sits beside the real clock in the common peripheral group and is configured by the register front-end.

---
 rtl/ervp_real_clock_alarm_scheduler.sv | 163 ++++++++++++++++
 tb/tb_ervp_real_clock_alarm_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ervp_real_clock_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// ervp_real_clock_alarm_scheduler
//
// Multi-channel alarm scheduler for the free-running microsecond real clock.
// Each channel holds an absolute target time and an optional reload period.
// A single magnitude comparator is shared by all channels through a
// round-robin scan pointer that advances every cycle.
//
// Ports:
//   clk            system clock
//   rstnn          synchronous active-low reset
//   real_clock     current time (microseconds, monotonic)
//   cfg_arm        arm channel cfg_index with cfg_time / cfg_period
//   cfg_cancel     disarm channel cfg_index (cfg_arm has priority)
//   cfg_index      target channel of cfg_arm / cfg_cancel
//   cfg_time       absolute fire time
//   cfg_period     reload period, 0 = one-shot
//   pending_clear  write-1-to-clear for the pending flags
//   irq_enable     per-channel interrupt mask
//   armed          per-channel armed flags
//   pending        per-channel sticky fired flags
//   fire_pulse     one-cycle pulse per fire event
//   irq            OR of (pending AND irq_enable)
// ---------------------------------------------------------------------------
module ervp_real_clock_alarm_scheduler #(
    parameter int NUM_ALARM = 4,
    parameter int BW_TIME   = 64,
    parameter int BW_PERIOD = 32,
    parameter int BW_INDEX  = $clog2(NUM_ALARM)
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic [BW_TIME-1:0]   real_clock,
    input  logic                 cfg_arm,
    input  logic                 cfg_cancel,
    input  logic [BW_INDEX-1:0]  cfg_index,
    input  logic [BW_TIME-1:0]   cfg_time,
    input  logic [BW_PERIOD-1:0] cfg_period,
    input  logic [NUM_ALARM-1:0] pending_clear,
    input  logic [NUM_ALARM-1:0] irq_enable,
    output logic [NUM_ALARM-1:0] armed,
    output logic [NUM_ALARM-1:0] pending,
    output logic [NUM_ALARM-1:0] fire_pulse,
    output logic                 irq
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BW_INDEX-1:0]  ptr_q, ptr_d;
    logic [BW_TIME-1:0]   target_q [NUM_ALARM];
    logic [BW_TIME-1:0]   target_d [NUM_ALARM];
    logic [BW_PERIOD-1:0] period_q [NUM_ALARM];
    logic [BW_PERIOD-1:0] period_d [NUM_ALARM];
    logic [NUM_ALARM-1:0] armed_q, armed_d;
    logic [NUM_ALARM-1:0] pending_q, pending_d;
    logic [NUM_ALARM-1:0] fire_pulse_q, fire_pulse_d;

    // ------------------------------------------------------------------
    // Per-channel decode of the configuration target and the scan pointer
    // ------------------------------------------------------------------
    logic                 cfg_valid;
    logic [NUM_ALARM-1:0] cfg_sel;
    logic [NUM_ALARM-1:0] ptr_sel;

    // Out-of-range indices (possible when NUM_ALARM is not a power of two)
    // are dropped here so they never reach any channel.
    assign cfg_valid = ({1'b0, cfg_index} < (BW_INDEX+1)'(NUM_ALARM));

    generate
        for (genvar gi = 0; gi < NUM_ALARM; gi++) begin : g_sel
            assign cfg_sel[gi] = cfg_valid && (cfg_index == BW_INDEX'(gi));
            assign ptr_sel[gi] = (ptr_q == BW_INDEX'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared comparator on the channel under the scan pointer
    // ------------------------------------------------------------------
    logic [BW_TIME-1:0] cur_target;
    logic               cfg_touch_ptr;
    logic               hit;
    logic               fire;

    always_comb begin
        cur_target    = target_q[ptr_q];
        hit           = armed_q[ptr_q] && (real_clock >= cur_target);
        // A configuration write to the visited channel takes precedence over
        // its hit: the visit is suppressed entirely.
        cfg_touch_ptr = (cfg_arm || cfg_cancel) && |(cfg_sel & ptr_sel);
        fire          = hit && !cfg_touch_ptr;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d        = (ptr_q == BW_INDEX'(NUM_ALARM - 1)) ? '0 : ptr_q + 1'b1;
        armed_d      = armed_q;
        pending_d    = pending_q & ~pending_clear;
        fire_pulse_d = '0;
        for (int i = 0; i < NUM_ALARM; i++) begin
            target_d[i] = target_q[i];
            period_d[i] = period_q[i];

            // Set after clear so a hit beats a simultaneous pending_clear.
            if (fire && ptr_sel[i]) begin
                pending_d[i]    = 1'b1;
                fire_pulse_d[i] = 1'b1;
                if (period_q[i] == '0) begin
                    armed_d[i] = 1'b0;
                end else begin
                    // Wraps modulo 2^BW_TIME; catch-up happens naturally on
                    // later visits while the new target is still in the past.
                    target_d[i] = target_q[i] + BW_TIME'(period_q[i]);
                end
            end

            if (cfg_arm && cfg_sel[i]) begin
                target_d[i]  = cfg_time;
                period_d[i]  = cfg_period;
                armed_d[i]   = 1'b1;
                pending_d[i] = 1'b0;
            end else if (cfg_cancel && cfg_sel[i]) begin
                armed_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            ptr_q        <= '0;
            armed_q      <= '0;
            pending_q    <= '0;
            fire_pulse_q <= '0;
            for (int i = 0; i < NUM_ALARM; i++) begin
                target_q[i] <= '0;
                period_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            fire_pulse_q <= fire_pulse_d;
            for (int i = 0; i < NUM_ALARM; i++) begin
                target_q[i] <= target_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign armed      = armed_q;
    assign pending    = pending_q;
    assign fire_pulse = fire_pulse_q;
    assign irq        = |(pending_q & irq_enable);

endmodule

// File: tb/tb_ervp_real_clock_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for ervp_real_clock_alarm_scheduler (NUM_ALARM = 4).
// A behavioural model tracks every channel from the visit order
// (visit = cycles since reset modulo NUM_ALARM) and is compared against the
// DUT after every clock edge; table vectors and hand-written sequences add
// hand-derived expectations on top.
// ---------------------------------------------------------------------------
module tb_ervp_real_clock_alarm_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic [63:0] real_clock = '0;
    logic        cfg_arm = 1'b0;
    logic        cfg_cancel = 1'b0;
    logic [1:0]  cfg_index = '0;
    logic [63:0] cfg_time = '0;
    logic [31:0] cfg_period = '0;
    logic [3:0]  pending_clear = '0;
    logic [3:0]  irq_enable = '0;
    logic [3:0]  armed, pending, fire_pulse;
    logic        irq;

    ervp_real_clock_alarm_scheduler #(
        .NUM_ALARM(4), .BW_TIME(64), .BW_PERIOD(32)
    ) dut (
        .clk(clk), .rstnn(rstnn), .real_clock(real_clock),
        .cfg_arm(cfg_arm), .cfg_cancel(cfg_cancel), .cfg_index(cfg_index),
        .cfg_time(cfg_time), .cfg_period(cfg_period),
        .pending_clear(pending_clear), .irq_enable(irq_enable),
        .armed(armed), .pending(pending), .fire_pulse(fire_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [63:0] m_target [N];
    logic [31:0] m_period [N];
    logic [3:0]  m_armed, m_pending, m_fire;
    int          m_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int   v;
        logic collide;
        if (!rstnn) begin
            for (int i = 0; i < N; i++) begin
                m_target[i] = '0;
                m_period[i] = '0;
            end
            m_armed = '0; m_pending = '0; m_fire = '0; m_cyc = 0;
            return;
        end
        v       = m_cyc % N;
        collide = (cfg_arm || cfg_cancel) && (int'(cfg_index) == v);
        m_fire  = '0;
        m_pending = m_pending & ~pending_clear;
        if (m_armed[v] && (real_clock >= m_target[v]) && !collide) begin
            m_pending[v] = 1'b1;
            m_fire[v]    = 1'b1;
            if (m_period[v] == 0) m_armed[v] = 1'b0;
            else m_target[v] = m_target[v] + 64'(m_period[v]);
        end
        if (cfg_arm) begin
            m_target[cfg_index]  = cfg_time;
            m_period[cfg_index]  = cfg_period;
            m_armed[cfg_index]   = 1'b1;
            m_pending[cfg_index] = 1'b0;
        end else if (cfg_cancel) begin
            m_armed[cfg_index] = 1'b0;
        end
        m_cyc++;
    endtask

    // One clock cycle: advance the model with the current inputs, then
    // compare the DUT shortly after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("model_armed", 64'(armed), 64'(m_armed));
        chk("model_pending", 64'(pending), 64'(m_pending));
        chk("model_fire_pulse", 64'(fire_pulse), 64'(m_fire));
        chk("model_irq", 64'(irq), 64'(|(m_pending & irq_enable)));
    endtask

    task automatic clear_cfg();
        cfg_arm = 1'b0; cfg_cancel = 1'b0; pending_clear = '0;
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        clear_cfg();
        for (int i = 0; i < 3; i++) step();
        chk("reset_armed", 64'(armed), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_fire", 64'(fire_pulse), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        rstnn = 1'b1;
    endtask

    typedef struct {
        logic        arm;
        logic        cancel;
        logic [1:0]  idx;
        logic [63:0] tm;
        logic [31:0] per;
        logic [63:0] rc;
        logic [3:0]  pclr;
        logic [3:0]  ien;
        logic [3:0]  e_armed;
        logic [3:0]  e_pend;
        logic [3:0]  e_fire;
        logic        e_irq;
    } vec_t;

    vec_t vecs [19];
    logic [3:0] fp [8];

    initial begin
        int cnt;
        int first;
        int ch0;
        logic [3:0] want;
        logic [3:0] seen;

        // Rows start on the first cycle after reset (scan pointer = 0).
        //          arm  can idx  time      per    rc        pclr  ien   armed pend  fire  irq
        vecs[0]  = '{1'b1,1'b0,2'd2,64'd1000,32'd0,64'd100, 4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[1]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd100, 4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[2]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd999, 4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[3]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[4]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[5]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h4,4'h0,4'h0,1'b0};
        vecs[6]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h0,4'h4,4'h4,1'b1};
        vecs[7]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h0,4'h4,4'h0,1'b1};
        vecs[8]  = '{1'b1,1'b0,2'd0,64'd50,  32'd0,64'd1000,4'h0,4'h4, 4'h1,4'h4,4'h0,1'b1};
        vecs[9]  = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h1,4'h4,4'h0,1'b1};
        vecs[10] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h1,4'h4,4'h0,1'b1};
        vecs[11] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h1,4'h4,4'h0,1'b1};
        vecs[12] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h4, 4'h0,4'h5,4'h1,1'b1};
        vecs[13] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h5,4'h5, 4'h0,4'h0,4'h0,1'b0};
        vecs[14] = '{1'b1,1'b0,2'd3,64'd0,   32'd0,64'd1000,4'h0,4'h5, 4'h8,4'h0,4'h0,1'b0};
        vecs[15] = '{1'b0,1'b1,2'd3,64'd0,   32'd0,64'd1000,4'h0,4'h5, 4'h0,4'h0,4'h0,1'b0};
        vecs[16] = '{1'b1,1'b1,2'd1,64'd0,   32'd0,64'd1000,4'h0,4'h5, 4'h2,4'h0,4'h0,1'b0};
        vecs[17] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h2,4'h5, 4'h0,4'h2,4'h2,1'b0};
        vecs[18] = '{1'b0,1'b0,2'd0,64'd0,   32'd0,64'd1000,4'h0,4'h2, 4'h0,4'h2,4'h0,1'b1};

        // ---------------- Reset + table vectors ----------------
        real_clock = 64'd100;
        do_reset();
        for (int r = 0; r < 19; r++) begin
            cfg_arm = vecs[r].arm; cfg_cancel = vecs[r].cancel;
            cfg_index = vecs[r].idx; cfg_time = vecs[r].tm; cfg_period = vecs[r].per;
            real_clock = vecs[r].rc; pending_clear = vecs[r].pclr; irq_enable = vecs[r].ien;
            step();
            chk($sformatf("vec%0d_armed", r), 64'(armed), 64'(vecs[r].e_armed));
            chk($sformatf("vec%0d_pending", r), 64'(pending), 64'(vecs[r].e_pend));
            chk($sformatf("vec%0d_fire", r), 64'(fire_pulse), 64'(vecs[r].e_fire));
            chk($sformatf("vec%0d_irq", r), 64'(irq), 64'(vecs[r].e_irq));
            $display("vec %0d: armed=%h pending=%h fire=%h irq=%b", r, armed, pending, fire_pulse, irq);
        end
        clear_cfg();

        // ---------------- Periodic catch-up ----------------
        real_clock = 64'd0;
        do_reset();
        cfg_arm = 1'b1; cfg_index = 2'd1; cfg_time = 64'd10; cfg_period = 32'd10;
        step();
        clear_cfg();
        real_clock = 64'd35;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt += int'(fire_pulse[1]);
        end
        chk("catchup_fires", 64'(cnt), 64'd3);
        chk("catchup_armed", 64'(armed[1]), 64'd1);
        $display("catch-up: %0d fires at real_clock=35, armed[1]=%b", cnt, armed[1]);
        real_clock = 64'd39;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(fire_pulse[1]);
        end
        chk("catchup_no_early_fire", 64'(cnt), 64'd0);
        real_clock = 64'd40;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(fire_pulse[1]);
        end
        chk("catchup_target40_fire", 64'(cnt), 64'd1);
        $display("catch-up: target 40 fired %0d time(s)", cnt);

        // ---------------- All channels at once ----------------
        real_clock = 64'd100;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cfg_arm = 1'b1; cfg_index = 2'(i); cfg_time = 64'd200; cfg_period = 32'd0;
            step();
        end
        clear_cfg();
        real_clock = 64'd200;
        for (int k = 0; k < 8; k++) begin
            step();
            fp[k] = fire_pulse;
        end
        cnt = 0; first = -1; seen = '0;
        for (int k = 0; k < 8; k++) begin
            cnt += $countones(fp[k]);
            seen |= fp[k];
            if (first < 0 && fp[k] != 0) first = k;
        end
        chk("all_total_pulses", 64'(cnt), 64'd4);
        chk("all_each_channel", 64'(seen), 64'hF);
        if (first >= 0 && first <= 4) begin
            ch0 = 0;
            for (int c = 0; c < N; c++) if (fp[first][c]) ch0 = c;
            for (int k = 0; k < N; k++) begin
                want = 4'b0001 << ((ch0 + k) % N);
                chk($sformatf("all_order_%0d", k), 64'(fp[first + k]), 64'(want));
            end
        end else begin
            chk("all_first_pulse_in_window", 64'(first), 64'd0);
        end
        $display("all-channels: %0d pulses, first at cycle %0d", cnt, first);

        // ---------------- Randomized vs model ----------------
        real_clock = 64'd0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rstnn      = ($urandom_range(0, 499) != 0);
            cfg_arm    = ($urandom_range(0, 7) == 0);
            cfg_cancel = ($urandom_range(0, 9) == 0);
            cfg_index  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                cfg_time = (real_clock > 64'd30) ? real_clock - 64'($urandom_range(0, 30)) : 64'd0;
            else
                cfg_time = real_clock + 64'($urandom_range(0, 60));
            cfg_period    = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            pending_clear = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            irq_enable    = 4'($urandom);
            real_clock    = real_clock + 64'($urandom_range(0, 3));
            step();
        end
        rstnn = 1'b1;
        clear_cfg();
        $display("random: 3000 cycles done, real_clock=%0d", real_clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
